// File: rtl/vga_pkg.sv
// Shared defaults for the VGA layer compositor: 640x480@60 timing, colour widths, pixel type.
// Parameters of the blocks default to these values and may be overridden per instance.
package vga_pkg;

    localparam int PIX_DIV_DEF   = 4;
    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;
    localparam bit SYNC_POL_DEF  = 1'b0;

    localparam int CW_DEF      = 4;
    localparam int COORD_W_DEF = 10;

    typedef struct packed {
        logic [CW_DEF-1:0] r;
        logic [CW_DEF-1:0] g;
        logic [CW_DEF-1:0] b;
    } rgb_t;

    localparam rgb_t BG_COLOR_DEF  = 12'hFFF;
    localparam rgb_t KEY_COLOR_DEF = 12'hF0F;

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-clock divider, H/V raster counters, sync/visible decode and frame-wrap strobe.
// Latency: decodes are combinational from the counters; free-running, no backpressure.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int PIX_DIV   = PIX_DIV_DEF,
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF,
    parameter int COORD_W   = COORD_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    output logic               pix_ce_o,
    output logic [COORD_W-1:0] hcount_o,
    output logic [COORD_W-1:0] vcount_o,
    output logic               visible_o,
    output logic               hsync_act_o,
    output logic               vsync_act_o,
    output logic               wrap_o
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    logic [DIV_W-1:0]   div_q, div_d;
    logic [COORD_W-1:0] h_q, h_d, v_q, v_d;
    logic               h_end, v_end;

    // With PIX_DIV=1 the divider stays at 0, which equals PIX_DIV-1, so pix_ce is constant.
    assign pix_ce_o = (div_q == DIV_W'(PIX_DIV - 1));
    assign h_end    = (h_q == COORD_W'(H_TOTAL - 1));
    assign v_end    = (v_q == COORD_W'(V_TOTAL - 1));

    always_comb begin
        div_d = pix_ce_o ? '0 : div_q + 1'b1;
        h_d   = h_q;
        v_d   = v_q;
        if (pix_ce_o) begin
            if (h_end) begin
                h_d = '0;
                v_d = v_end ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    assign hcount_o    = h_q;
    assign vcount_o    = v_q;
    assign visible_o   = (h_q < COORD_W'(H_VISIBLE)) && (v_q < COORD_W'(V_VISIBLE));
    assign hsync_act_o = (h_q >= COORD_W'(HS_START)) && (h_q < COORD_W'(HS_START + H_SYNC));
    assign vsync_act_o = (v_q >= COORD_W'(VS_START)) && (v_q < COORD_W'(VS_START + V_SYNC));
    assign wrap_o      = pix_ce_o && h_end && v_end;

endmodule

// File: rtl/vga_layer_compositor.sv
// Fixed-priority colour-keyed sprite compositor over VGA timing, frame-shadowed config, overlap flags.
// Latency: RGB/syncs registered one pixel (PIX_DIV clk) after Hcount/Vcount; free-running, no backpressure.
module vga_layer_compositor
    import vga_pkg::*;
#(
    parameter int             PIX_DIV    = PIX_DIV_DEF,
    parameter int             H_VISIBLE  = H_VISIBLE_DEF,
    parameter int             H_FRONT    = H_FRONT_DEF,
    parameter int             H_SYNC     = H_SYNC_DEF,
    parameter int             H_BACK     = H_BACK_DEF,
    parameter int             V_VISIBLE  = V_VISIBLE_DEF,
    parameter int             V_FRONT    = V_FRONT_DEF,
    parameter int             V_SYNC     = V_SYNC_DEF,
    parameter int             V_BACK     = V_BACK_DEF,
    parameter bit             SYNC_POL   = SYNC_POL_DEF,
    parameter int             NUM_LAYERS = 4,
    parameter int             CW         = CW_DEF,
    parameter int             COORD_W    = COORD_W_DEF,
    parameter logic [3*CW-1:0] BG_COLOR  = BG_COLOR_DEF,
    parameter logic [3*CW-1:0] KEY_COLOR = KEY_COLOR_DEF
) (
    input  logic                          clk,
    input  logic                          resetButton,
    input  logic [NUM_LAYERS-1:0]         layer_en,
    input  logic [NUM_LAYERS-1:0]         layer_key_en,
    input  logic [NUM_LAYERS*COORD_W-1:0] layer_x0,
    input  logic [NUM_LAYERS*COORD_W-1:0] layer_x1,
    input  logic [NUM_LAYERS*COORD_W-1:0] layer_y0,
    input  logic [NUM_LAYERS*COORD_W-1:0] layer_y1,
    input  logic [NUM_LAYERS*3*CW-1:0]    layer_rgb,
    output logic [COORD_W-1:0]            Hcount,
    output logic [COORD_W-1:0]            Vcount,
    output logic                          pix_ce,
    output logic                          frame_start,
    output logic [NUM_LAYERS-1:0]         overlap_flags,
    output logic                          Hsynq,
    output logic                          Vsynq,
    output logic [CW-1:0]                 Red,
    output logic [CW-1:0]                 Green,
    output logic [CW-1:0]                 Blue
);

    typedef struct packed {
        logic [CW-1:0] r;
        logic [CW-1:0] g;
        logic [CW-1:0] b;
    } pix_t;

    logic visible, hsync_act, vsync_act, wrap;

    vga_timing_gen #(
        .PIX_DIV   (PIX_DIV),
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK),
        .COORD_W   (COORD_W)
    ) u_timing (
        .clk_i       (clk),
        .rst_ni      (resetButton),
        .pix_ce_o    (pix_ce),
        .hcount_o    (Hcount),
        .vcount_o    (Vcount),
        .visible_o   (visible),
        .hsync_act_o (hsync_act),
        .vsync_act_o (vsync_act),
        .wrap_o      (wrap)
    );

    logic [NUM_LAYERS-1:0]         en_q, key_en_q;
    logic [NUM_LAYERS*COORD_W-1:0] x0_q, x1_q, y0_q, y1_q;
    logic [NUM_LAYERS-1:0]         opaque, hit;
    logic [NUM_LAYERS-1:0]         acc_q, acc_d, ovl_q;
    pix_t                          rgb_q, rgb_d;
    logic                          hs_q, vs_q;

    // An inverted window (x0 >= x1 or y0 >= y1) can never satisfy both bounds, so it is empty.
    always_comb begin
        opaque = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            opaque[i] = en_q[i]
                && (Hcount >= x0_q[i*COORD_W +: COORD_W]) && (Hcount < x1_q[i*COORD_W +: COORD_W])
                && (Vcount >= y0_q[i*COORD_W +: COORD_W]) && (Vcount < y1_q[i*COORD_W +: COORD_W])
                && !(key_en_q[i] && (layer_rgb[i*3*CW +: 3*CW] == KEY_COLOR));
        end
    end

    // Walk from the highest index down so the lowest-index opaque layer is written last and wins.
    always_comb begin
        rgb_d = '0;
        if (visible) begin
            rgb_d = BG_COLOR;
            for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
                if (opaque[i]) begin
                    rgb_d = layer_rgb[i*3*CW +: 3*CW];
                end
            end
        end
    end

    // The wrap pixel is never visible, so clearing and accumulating cannot collide.
    always_comb begin
        hit = '0;
        for (int i = 1; i < NUM_LAYERS; i++) begin
            hit[i] = opaque[0] & opaque[i];
        end
        acc_d = acc_q;
        if (wrap) begin
            acc_d = '0;
        end else if (pix_ce && visible) begin
            acc_d = acc_q | hit;
        end
    end

    always_ff @(posedge clk or negedge resetButton) begin
        if (!resetButton) begin
            en_q     <= '0;
            key_en_q <= '0;
            x0_q     <= '0;
            x1_q     <= '0;
            y0_q     <= '0;
            y1_q     <= '0;
            acc_q    <= '0;
            ovl_q    <= '0;
            rgb_q    <= '0;
            hs_q     <= ~SYNC_POL;
            vs_q     <= ~SYNC_POL;
        end else begin
            acc_q <= acc_d;
            if (wrap) begin
                en_q     <= layer_en;
                key_en_q <= layer_key_en;
                x0_q     <= layer_x0;
                x1_q     <= layer_x1;
                y0_q     <= layer_y0;
                y1_q     <= layer_y1;
                ovl_q    <= acc_q;
            end
            if (pix_ce) begin
                rgb_q <= rgb_d;
                hs_q  <= hsync_act ? SYNC_POL : ~SYNC_POL;
                vs_q  <= vsync_act ? SYNC_POL : ~SYNC_POL;
            end
        end
    end

    assign frame_start   = wrap;
    assign overlap_flags = ovl_q;
    assign Hsynq         = hs_q;
    assign Vsynq         = vs_q;
    assign Red           = rgb_q.r;
    assign Green         = rgb_q.g;
    assign Blue          = rgb_q.b;

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Scoreboard bench on a shrunken raster (40x30 total, 32x24 visible, PIX_DIV=2).
// Directed probe pixels carry hand-computed RGB/sync values; a monitor pops them as the DUT emits them.
module tb_vga_layer_compositor;

    localparam int PIX_DIV = 2;
    localparam int NL      = 4;
    localparam int CW      = 4;
    localparam int CWW     = 10;
    localparam int LIMIT   = 3000;

    logic                clk = 1'b0;
    logic                resetButton = 1'b0;
    logic [NL-1:0]       layer_en = '0;
    logic [NL-1:0]       layer_key_en = '0;
    logic [NL*CWW-1:0]   layer_x0 = '0;
    logic [NL*CWW-1:0]   layer_x1 = '0;
    logic [NL*CWW-1:0]   layer_y0 = '0;
    logic [NL*CWW-1:0]   layer_y1 = '0;
    logic [NL*3*CW-1:0]  layer_rgb = '0;
    logic [CWW-1:0]      Hcount, Vcount;
    logic                pix_ce, frame_start, Hsynq, Vsynq;
    logic [NL-1:0]       overlap_flags;
    logic [CW-1:0]       Red, Green, Blue;

    int n_cmp = 0;
    int n_err = 0;

    vga_layer_compositor #(
        .PIX_DIV (PIX_DIV), .H_VISIBLE (32), .H_FRONT (2), .H_SYNC (4), .H_BACK (2),
        .V_VISIBLE (24), .V_FRONT (2), .V_SYNC (2), .V_BACK (2), .SYNC_POL (1'b0),
        .NUM_LAYERS (NL), .CW (CW), .COORD_W (CWW),
        .BG_COLOR (12'hFFF), .KEY_COLOR (12'hF0F)
    ) dut (
        .clk (clk), .resetButton (resetButton),
        .layer_en (layer_en), .layer_key_en (layer_key_en),
        .layer_x0 (layer_x0), .layer_x1 (layer_x1), .layer_y0 (layer_y0), .layer_y1 (layer_y1),
        .layer_rgb (layer_rgb),
        .Hcount (Hcount), .Vcount (Vcount), .pix_ce (pix_ce), .frame_start (frame_start),
        .overlap_flags (overlap_flags), .Hsynq (Hsynq), .Vsynq (Vsynq),
        .Red (Red), .Green (Green), .Blue (Blue)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int h;
        int v;
        int rgb;
        int hs;
        int vs;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit   armed = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int id, input int h, input int v, input int rgb, input int hs, input int vs);
        exp_t e;
        e.id = id; e.h = h; e.v = v; e.rgb = rgb; e.hs = hs; e.vs = vs;
        sb.push_back(e);
    endtask

    // Pixel (h,v) seen with pix_ce high is registered on the next edge; compare one clk later.
    always @(negedge clk) begin
        if (armed) begin
            armed = 1'b0;
            check($sformatf("p%0d_rgb", cur.id), int'({Red, Green, Blue}), cur.rgb);
            check($sformatf("p%0d_hsync", cur.id), int'(Hsynq), cur.hs);
            check($sformatf("p%0d_vsync", cur.id), int'(Vsynq), cur.vs);
        end
        if (resetButton && pix_ce && sb.size() > 0
            && int'(Hcount) == sb[0].h && int'(Vcount) == sb[0].v) begin
            cur   = sb.pop_front();
            armed = 1'b1;
        end
    end

    task automatic set_win(input int i, input int x0, input int x1, input int y0, input int y1);
        layer_x0[i*CWW +: CWW] = CWW'(x0);
        layer_x1[i*CWW +: CWW] = CWW'(x1);
        layer_y0[i*CWW +: CWW] = CWW'(y0);
        layer_y1[i*CWW +: CWW] = CWW'(y1);
    endtask

    task automatic set_rgb(input int i, input int rgb);
        layer_rgb[i*3*CW +: 3*CW] = 12'(rgb);
    endtask

    task automatic next_frame();
        int g = 0;
        while (!frame_start && g < LIMIT) begin
            @(negedge clk);
            g++;
        end
        check("frame_start_seen", int'(g < LIMIT), 1);
        @(negedge clk);
        check("unmatched_probes", sb.size(), 0);
        sb.delete();
    endtask

    task automatic wait_pix(input int h, input int v);
        int g = 0;
        while (!(pix_ce && int'(Hcount) == h && int'(Vcount) == v) && g < LIMIT) begin
            @(negedge clk);
            g++;
        end
        check($sformatf("reach_%0d_%0d", h, v), int'(g < LIMIT), 1);
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((sb.size() > 0 || armed) && g < LIMIT) begin
            @(negedge clk);
            g++;
        end
        check("unmatched_probes", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        int clk_n, pce_n, hs_lo, vs_lo, g;

        // layer0 green [4,10)x[6,12), layer1 red [8,20)x[6,14), layer2 blue bottom band, layer3 disabled.
        set_win(0, 4, 10, 6, 12);  set_rgb(0, 12'h0F0);
        set_win(1, 8, 20, 6, 14);  set_rgb(1, 12'hF00);
        set_win(2, 0, 32, 20, 24); set_rgb(2, 12'h00F);
        set_win(3, 0, 32, 0, 24);  set_rgb(3, 12'h333);
        layer_en = 4'b0111;
        layer_key_en = 4'b0000;

        repeat (3) @(negedge clk);
        check("rst_rgb", int'({Red, Green, Blue}), 0);
        check("rst_hsync", int'(Hsynq), 1);
        check("rst_vsync", int'(Vsynq), 1);
        check("rst_hcount", int'(Hcount), 0);
        check("rst_vcount", int'(Vcount), 0);
        check("rst_overlap", int'(overlap_flags), 0);
        check("rst_frame_start", int'(frame_start), 0);

        resetButton = 1'b1;
        repeat (PIX_DIV - 1) @(posedge clk);
        #1 check("hcount_before_first_ce", int'(Hcount), 0);
        @(posedge clk);
        #1 check("hcount_after_first_ce", int'(Hcount), 1);
        @(negedge clk);

        // Frame 0: shadows still cleared, so the layer0 area shows background.
        push(1, 6, 8, 12'hFFF, 1, 1);
        next_frame();
        check("ovl_after_f0", int'(overlap_flags), 0);

        // Frame 1: priority, window edges, blanking and syncs; count timing over the whole frame.
        push(10, 33, 5, 12'h000, 1, 1);
        push(11, 35, 5, 12'h000, 0, 1);
        push(12, 4, 6, 12'h0F0, 1, 1);
        push(13, 3, 8, 12'hFFF, 1, 1);
        push(14, 6, 8, 12'h0F0, 1, 1);
        push(15, 10, 8, 12'hF00, 1, 1);
        push(16, 14, 8, 12'hF00, 1, 1);
        push(17, 20, 8, 12'hFFF, 1, 1);
        push(18, 8, 14, 12'hFFF, 1, 1);
        push(19, 25, 17, 12'hFFF, 1, 1);
        push(20, 5, 21, 12'h00F, 1, 1);
        push(21, 31, 23, 12'h00F, 1, 1);
        push(22, 5, 26, 12'h000, 1, 0);
        layer_key_en = 4'b0001;
        clk_n = 0; pce_n = 0; hs_lo = 0; vs_lo = 0; g = 0;
        while (g < LIMIT) begin
            clk_n++;
            if (pix_ce) begin
                pce_n++;
                if (!Hsynq) hs_lo++;
                if (!Vsynq) vs_lo++;
            end
            if (frame_start) break;
            @(negedge clk);
            g++;
        end
        check("clk_per_frame", clk_n, 2400);
        check("pce_per_frame", pce_n, 1200);
        check("hsync_low_pce", hs_lo, 120);
        check("vsync_low_pce", vs_lo, 80);
        @(negedge clk);
        check("frame_start_one_clk", int'(frame_start), 0);
        check("unmatched_probes", sb.size(), 0);
        sb.delete();
        check("ovl_after_f1", int'(overlap_flags), 4'b0010);

        // Frame 2: layer0 is the key colour with keying on, so it is transparent everywhere.
        set_rgb(0, 12'hF0F);
        layer_key_en = 4'b0000;
        push(30, 6, 8, 12'hFFF, 1, 1);
        push(31, 9, 8, 12'hF00, 1, 1);
        next_frame();
        check("ovl_after_f2", int'(overlap_flags), 0);

        // Frame 3: keying off shows the magenta; layer1 move at V=10 must not affect this frame.
        push(40, 9, 8, 12'hF0F, 1, 1);
        push(41, 14, 8, 12'hF00, 1, 1);
        push(42, 14, 13, 12'hF00, 1, 1);
        push(43, 24, 13, 12'hFFF, 1, 1);
        wait_pix(0, 10);
        set_win(1, 22, 30, 6, 14);
        next_frame();
        check("ovl_after_f3", int'(overlap_flags), 4'b0010);

        // Frame 4: layer1 now at [22,30).
        push(50, 6, 8, 12'hF0F, 1, 1);
        push(51, 14, 8, 12'hFFF, 1, 1);
        push(52, 24, 8, 12'hF00, 1, 1);
        push(53, 35, 8, 12'h000, 0, 1);
        next_frame();
        check("ovl_after_f4", int'(overlap_flags), 0);

        set_win(1, 8, 20, 6, 14);
        next_frame();
        check("ovl_after_f5", int'(overlap_flags), 0);
        next_frame();
        check("ovl_after_f6", int'(overlap_flags), 4'b0010);

        // Frame 7: reset after the overlap rows, with the accumulator holding bit 1.
        wait_pix(0, 15);
        resetButton = 1'b0;
        #1;
        check("midrst_rgb", int'({Red, Green, Blue}), 0);
        check("midrst_hsync", int'(Hsynq), 1);
        check("midrst_vsync", int'(Vsynq), 1);
        check("midrst_overlap", int'(overlap_flags), 0);
        check("midrst_hcount", int'(Hcount), 0);
        check("midrst_vcount", int'(Vcount), 0);
        repeat (3) @(negedge clk);
        resetButton = 1'b1;

        push(60, 6, 8, 12'hFFF, 1, 1);
        next_frame();
        check("ovl_after_rst_frame", int'(overlap_flags), 0);
        push(61, 6, 8, 12'hF0F, 1, 1);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_layer_compositor.md
Name: vga_layer_compositor

Overview:
- Parametrised successor to the hard-wired top-level pixel mux.
- Generates VGA timing from a divided pixel-clock enable and exposes the active coordinates.
- Composites NUM_LAYERS rectangular sprite layers by fixed priority, with per-layer colour-key transparency, over a background colour.
- Adds frame-synchronous (tear-free) shadowing of window and enable registers, plus per-frame overlap detection between layer 0 (player) and every other layer. Game logic uses the overlap flags for collision.

Parameters:
- PIX_DIV, 4: clk cycles per pixel; pix_ce pulses once every PIX_DIV clk cycles; must be >=1.
- H_VISIBLE, 640: visible pixels per line.
- H_FRONT, 16: horizontal front porch.
- H_SYNC, 96: horizontal sync width.
- H_BACK, 48: horizontal back porch.
- V_VISIBLE, 480: visible lines.
- V_FRONT, 10: vertical front porch.
- V_SYNC, 2: vertical sync width.
- V_BACK, 33: vertical back porch.
- SYNC_POL, 0: active level of Hsynq and Vsynq.
- NUM_LAYERS, 4: sprite layer count; must be >=2.
- CW, 4: bits per colour channel.
- COORD_W, 10: coordinate width.
- BG_COLOR, 12'hFFF: background {R,G,B}; width 3*CW.
- KEY_COLOR, 12'hF0F: transparency key {R,G,B}; width 3*CW.

Ports:
- clk  in  1  system clock (100 MHz).
- resetButton  in  1  asynchronous, active-low reset.
- layer_en  in  NUM_LAYERS  per-layer enable; shadowed.
- layer_key_en  in  NUM_LAYERS  per-layer colour-key enable; shadowed.
- layer_x0  in  NUM_LAYERS*COORD_W  window left edge, inclusive; shadowed.
- layer_x1  in  NUM_LAYERS*COORD_W  window right edge, exclusive; shadowed.
- layer_y0  in  NUM_LAYERS*COORD_W  window top edge, inclusive; shadowed.
- layer_y1  in  NUM_LAYERS*COORD_W  window bottom edge, exclusive; shadowed.
- layer_rgb  in  NUM_LAYERS*3*CW  layer colours; combinational function of Hcount/Vcount, valid in the same cycle.
- Hcount  out  COORD_W  current horizontal pixel counter.
- Vcount  out  COORD_W  current vertical line counter.
- pix_ce  out  1  pixel clock enable.
- frame_start  out  1  one-clk pulse on wrap to (0,0).
- overlap_flags  out  NUM_LAYERS  bit i set if layer 0 and layer i were both opaque on the same pixel in the previous frame; bit 0 is always 0.
- Hsynq  out  1  horizontal sync.
- Vsynq  out  1  vertical sync.
- Red  out  CW  red channel.
- Green  out  CW  green channel.
- Blue  out  CW  blue channel.

Behaviour:
- **Reset (async, resetButton=0):**
  - divider = 0; Hcount = Vcount = 0.
  - Red = Green = Blue = 0; Hsynq = Vsynq = ~SYNC_POL.
  - frame_start = 0; overlap_flags = 0; overlap accumulator = 0.
  - All shadow registers = 0, so all layers are disabled.
  - First pix_ce occurs PIX_DIV clk cycles after release.
- **Divider:** counts 0..PIX_DIV-1. pix_ce is high when count = PIX_DIV-1. With PIX_DIV=1, pix_ce is constantly high.
- **Counters:** advance only on pix_ce.
  - H_TOTAL = sum of the four H parameters; Hcount runs 0..H_TOTAL-1.
  - When Hcount wraps to 0, Vcount increments.
  - V_TOTAL = sum of the four V parameters; Vcount wraps to 0 after V_TOTAL-1.
  - Visible region: Hcount < H_VISIBLE and Vcount < V_VISIBLE.
  - Sync region, horizontal: H_VISIBLE+H_FRONT <= Hcount < H_VISIBLE+H_FRONT+H_SYNC.
  - Sync region, vertical: V_VISIBLE+V_FRONT <= Vcount < V_VISIBLE+V_FRONT+V_SYNC.
- **Shadowing:** on the pix_ce that wraps (H_TOTAL-1, V_TOTAL-1) to (0,0):
  - latch all shadowed inputs;
  - copy the accumulator to overlap_flags, then clear the accumulator;
  - pulse frame_start for that clk cycle.
  - Input changes at any other time take effect only at the next frame.
- **Opacity:** layer i is opaque at (H,V) when all of the following hold:
  - shadow en[i] = 1;
  - x0[i] <= H < x1[i] and y0[i] <= V < y1[i];
  - not (key_en[i] = 1 and layer_rgb[i] = KEY_COLOR).
  - A window with x0 >= x1 or y0 >= y1 is empty.
- **Priority:** the lowest-index opaque layer wins. If no layer is opaque, the pixel is BG_COLOR. Outside the visible region, RGB = 0.
- **Output pipeline:**
  - On pix_ce, the composite for the current (Hcount, Vcount) is registered into Red/Green/Blue.
  - Syncs are computed from the same coordinates and registered on the same pix_ce, so RGB and syncs stay aligned.
  - Latency is one pixel (PIX_DIV clk) from the Hcount/Vcount value to its RGB.
- **Overlap:** on a visible pix_ce, for each i >= 1, if layer 0 and layer i are both opaque, set accumulator bit i. Bits are sticky within the frame.
- **Simultaneous events:** a wrap and an overlap on the same pix_ce cannot occur, because pixel (H_TOTAL-1, V_TOTAL-1) is not visible.
- **Reset mid-frame:** everything returns to reset values immediately; no partial frame flags survive.

Decomposition:
- **Package vga_pkg:**
  - default 640x480@60 timing constants;
  - CW;
  - COORD_W;
  - an rgb struct/typedef {r,g,b};
  - BG_COLOR and KEY_COLOR defaults.
- **Sub-module vga_timing_gen:** divider, H/V counters, sync decode, visible flag and frame wrap. The compositor instantiates it once; layer mux, shadow registers and overlap logic stay in the top.

Test Plan:
1. **Reset and timing:** PIX_DIV=4, default timing, release reset. Required response:
   - pix_ce period 4 clk;
   - Hsynq=0 for exactly 96 pix_ce per 800;
   - Vsynq=0 for 2 lines per 525;
   - frame_start once per 420000 pix_ce.
2. **Priority:** layer0 {100..150)x{200..250) rgb 0x0F0; layer1 {120..300)x{200..260) rgb 0xF00; both enabled. Required response:
   - (130,210) outputs 0x0F0;
   - (200,210) outputs 0xF00;
   - (400,400) outputs 0xFFF;
   - blanking outputs 0.
3. **Colour key:** as test 2, with layer0 rgb = 0xF0F and key_en[0]=1. Required response: (130,210) outputs 0xF00; with key_en[0]=0 it outputs 0xF0F.
4. **Shadowing:** change layer1 x0 from 120 to 500 mid-frame at Vcount=100. Required response: the current frame still shows layer1 at 120; the next frame shows it at 500.
5. **Overlap:** with the test 2 windows, after the first full frame overlap_flags = 4'b0010. Move layer1 to x0=400; after two more frames overlap_flags = 0.
6. **Reset mid-frame:** assert resetButton=0 at Vcount=300. Required response: RGB=0, syncs=1, overlap_flags=0, Hcount=Vcount=0 immediately; layers stay disabled until the first frame wrap after release.
